adxl362_sequencer: RTL and testbench

- Sits above adxl362_controller and is its only driver.
- After reset it waits for sensor power-up, then writes POWER_CTL to enter measurement mode.
- It then periodically burst-reads XDATA/YDATA/ZDATA and presents an atomic 3-axis sample.
- It arbitrates the single controller between the periodic sampler and a manual register-access port used by top-level debug logic.

---
 rtl/adxl362_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_adxl362_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adxl362_sequencer.sv
// Drives adxl362_controller: power-up wait, POWER_CTL write, periodic X/Y/Z burst reads and a manual register port.
// Optional: define ADXL362_SEQ_TEMP_EN to append a TEMP_L read to each burst and expose it on temp.
module adxl362_sequencer #(
  parameter int unsigned CLK_FREQUENCY     = 100_000_000,
  parameter int unsigned SAMPLE_HZ         = 100,
  parameter int unsigned INIT_DELAY_CYCLES = 500_000,
  parameter logic [7:0]  POWER_CTL_VALUE   = 8'h02
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       man_req,
  input  logic       man_write,
  input  logic [7:0] man_addr,
  input  logic [7:0] man_wdata,
  output logic       man_ack,
  output logic [7:0] man_rdata,
  output logic       acc_start,
  output logic       acc_write,
  output logic [7:0] acc_address,
  output logic [7:0] acc_data_to_send,
  input  logic       acc_busy,
  input  logic       acc_done,
  input  logic [7:0] acc_data_received,
  output logic [7:0] accel_x,
  output logic [7:0] accel_y,
  output logic [7:0] accel_z,
  output logic       sample_valid,
  output logic       init_done,
  output logic       overrun
`ifdef ADXL362_SEQ_TEMP_EN
  ,
  output logic [7:0] temp
`endif
);

  localparam int unsigned PERIOD = CLK_FREQUENCY / SAMPLE_HZ;
  localparam int unsigned DW = (INIT_DELAY_CYCLES > 1) ? $clog2(INIT_DELAY_CYCLES) : 1;
  localparam int unsigned TW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
`ifdef ADXL362_SEQ_TEMP_EN
  localparam int unsigned NAXES = 4;
`else
  localparam int unsigned NAXES = 3;
`endif
  localparam logic [1:0] LAST_AXIS = 2'(NAXES - 1);

  typedef enum logic [2:0] {
    STARTUP, INIT_ISSUE, INIT_WAIT, IDLE, RD_ISSUE, RD_WAIT, MAN_ISSUE, MAN_WAIT
  } state_t;

  state_t                  state_q, state_d;
  logic [DW-1:0]           delayCnt_q, delayCnt_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic                    pending_q, pending_d;
  logic                    overrun_q, overrun_d;
  logic [1:0]              axis_q, axis_d;
  logic                    start_q, start_d;
  logic                    write_q, write_d;
  logic [7:0]              addr_q, addr_d;
  logic [7:0]              wdata_q, wdata_d;
  logic [NAXES-1:0][7:0]   shadow_q, shadow_d;
  logic [NAXES-1:0][7:0]   accel_q, accel_d;
  logic                    sampleValid_q, sampleValid_d;
  logic                    manAck_q, manAck_d;
  logic [7:0]              manRdata_q, manRdata_d;
  logic                    initDone_q, initDone_d;

  logic timerRun, tick, sampleReq, sampleClr;

  // Axis 3 is TEMP_L, which is not contiguous with the data registers.
  function automatic logic [7:0] axisAddr(input logic [1:0] n);
    return (n == 2'd3) ? 8'h14 : (8'h08 + {6'd0, n});
  endfunction

  assign timerRun  = enable && initDone_q;
  assign tick      = timerRun && (timer_q == TW'(PERIOD - 1));
  assign sampleReq = pending_q || tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= STARTUP;
      delayCnt_q    <= '0;
      timer_q       <= '0;
      pending_q     <= 1'b0;
      overrun_q     <= 1'b0;
      axis_q        <= 2'd0;
      start_q       <= 1'b0;
      write_q       <= 1'b0;
      addr_q        <= 8'h00;
      wdata_q       <= 8'h00;
      shadow_q      <= '0;
      accel_q       <= '0;
      sampleValid_q <= 1'b0;
      manAck_q      <= 1'b0;
      manRdata_q    <= 8'h00;
      initDone_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      delayCnt_q    <= delayCnt_d;
      timer_q       <= timer_d;
      pending_q     <= pending_d;
      overrun_q     <= overrun_d;
      axis_q        <= axis_d;
      start_q       <= start_d;
      write_q       <= write_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      shadow_q      <= shadow_d;
      accel_q       <= accel_d;
      sampleValid_q <= sampleValid_d;
      manAck_q      <= manAck_d;
      manRdata_q    <= manRdata_d;
      initDone_q    <= initDone_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    delayCnt_d    = delayCnt_q;
    axis_d        = axis_q;
    start_d       = 1'b0;
    write_d       = write_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    shadow_d      = shadow_q;
    accel_d       = accel_q;
    sampleValid_d = 1'b0;
    manAck_d      = 1'b0;
    manRdata_d    = manRdata_q;
    initDone_d    = initDone_q;
    sampleClr     = 1'b0;

    // Transfer parameters are loaded on the way into an ISSUE state so they are stable before the start pulse.
    case (state_q)
      STARTUP: begin
        if (delayCnt_q == DW'(INIT_DELAY_CYCLES - 1)) begin
          state_d = INIT_ISSUE;
          write_d = 1'b1;
          addr_d  = 8'h2D;
          wdata_d = POWER_CTL_VALUE;
        end else begin
          delayCnt_d = delayCnt_q + DW'(1);
        end
      end
      INIT_ISSUE: begin
        if (!acc_busy) begin
          start_d = 1'b1;
          state_d = INIT_WAIT;
        end
      end
      INIT_WAIT: begin
        if (acc_done) begin
          initDone_d = 1'b1;
          state_d    = IDLE;
        end
      end
      IDLE: begin
        // A tick arriving this very cycle still beats a manual request; the ack guard stops a held request re-firing.
        if (sampleReq) begin
          sampleClr = 1'b1;
          axis_d    = 2'd0;
          write_d   = 1'b0;
          addr_d    = axisAddr(2'd0);
          wdata_d   = 8'h00;
          state_d   = RD_ISSUE;
        end else if (man_req && !manAck_q) begin
          write_d = man_write;
          addr_d  = man_addr;
          wdata_d = man_write ? man_wdata : 8'h00;
          state_d = MAN_ISSUE;
        end
      end
      RD_ISSUE: begin
        if (!acc_busy) begin
          start_d = 1'b1;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (acc_done) begin
          shadow_d[axis_q] = acc_data_received;
          if (axis_q == LAST_AXIS) begin
            accel_d       = shadow_d;
            sampleValid_d = 1'b1;
            state_d       = IDLE;
          end else begin
            axis_d  = axis_q + 2'd1;
            addr_d  = axisAddr(axis_q + 2'd1);
            state_d = RD_ISSUE;
          end
        end
      end
      MAN_ISSUE: begin
        if (!acc_busy) begin
          start_d = 1'b1;
          state_d = MAN_WAIT;
        end
      end
      MAN_WAIT: begin
        if (acc_done) begin
          if (!write_q) manRdata_d = acc_data_received;
          manAck_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = STARTUP;
    endcase
  end

  // Sample timer: a tick that finds a request still outstanding is lost and flagged.
  always_comb begin
    timer_d   = timer_q;
    pending_d = pending_q;
    overrun_d = overrun_q;
    if (!timerRun) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else begin
      timer_d = tick ? '0 : timer_q + TW'(1);
      if (sampleClr) pending_d = pending_q && tick;
      else           pending_d = pending_q || tick;
      if (tick && pending_q && !sampleClr) overrun_d = 1'b1;
    end
  end

  assign man_ack          = manAck_q;
  assign man_rdata        = manRdata_q;
  assign acc_start        = start_q;
  assign acc_write        = write_q;
  assign acc_address      = addr_q;
  assign acc_data_to_send = wdata_q;
  assign accel_x          = accel_q[0];
  assign accel_y          = accel_q[1];
  assign accel_z          = accel_q[2];
`ifdef ADXL362_SEQ_TEMP_EN
  assign temp             = accel_q[3];
`endif
  assign sample_valid     = sampleValid_q;
  assign init_done        = initDone_q;
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_adxl362_sequencer.sv
// Scoreboard bench for adxl362_sequencer: a controller model answers transfers, a monitor checks every
// start/sample/ack event against expectations queued by the stimulus thread.
module tb_adxl362_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable, man_req, man_write;
  logic [7:0] man_addr, man_wdata;
  logic       man_ack;
  logic [7:0] man_rdata;
  logic       acc_start, acc_write;
  logic [7:0] acc_address, acc_data_to_send;
  logic       accBusy, accDone;
  logic [7:0] accRx;
  logic [7:0] accel_x, accel_y, accel_z;
  logic       sample_valid, init_done, overrun;
`ifdef ADXL362_SEQ_TEMP_EN
  logic [7:0] temp;
`endif

  adxl362_sequencer #(
    .CLK_FREQUENCY(200_000),
    .SAMPLE_HZ(1000),
    .INIT_DELAY_CYCLES(20),
    .POWER_CTL_VALUE(8'h02)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .man_req(man_req), .man_write(man_write), .man_addr(man_addr), .man_wdata(man_wdata),
    .man_ack(man_ack), .man_rdata(man_rdata),
    .acc_start(acc_start), .acc_write(acc_write), .acc_address(acc_address),
    .acc_data_to_send(acc_data_to_send), .acc_busy(accBusy), .acc_done(accDone),
    .acc_data_received(accRx),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .sample_valid(sample_valid), .init_done(init_done), .overrun(overrun)
`ifdef ADXL362_SEQ_TEMP_EN
    , .temp(temp)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;

  exp_t       expQ[$];
  int         sampleCyc[$];
  int         checks = 0, errors = 0, cyc = 0, latency = 5, lastXStart = 0;
  logic [7:0] rxX = 8'h00, rxY = 8'h00, rxZ = 8'h00, rxMan = 8'hAD;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  task automatic pushStart(input logic w, input logic [7:0] a, input logic [7:0] d);
    expQ.push_back('{0, {15'd0, w, a, d}});
  endtask

  task automatic pushBurst(input logic [7:0] x, input logic [7:0] y, input logic [7:0] z);
    pushStart(1'b0, 8'h08, 8'h00);
    pushStart(1'b0, 8'h09, 8'h00);
    pushStart(1'b0, 8'h0A, 8'h00);
    expQ.push_back('{1, {8'd0, x, y, z}});
  endtask

  task automatic pushAck(input logic [7:0] r);
    expQ.push_back('{2, {24'd0, r}});
  endtask

  task automatic popCompare(input int kind, input string name, input logic [31:0] act);
    exp_t e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("[TB] FAIL %s: unexpected event 0x%0h, required none", name, act);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind) begin
        errors++;
        $display("[TB] FAIL %s: event kind %0d value 0x%0h, required kind %0d value 0x%0h",
                 name, kind, act, e.kind, e.val);
      end else if (act !== e.val) begin
        errors++;
        $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, e.val);
      end
    end
  endtask

  // Monitor: every DUT-presented event is matched against the head of the expectation queue.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (acc_start) begin
        if (acc_address == 8'h08) lastXStart = cyc;
        popCompare(0, "start", {15'd0, acc_write, acc_address, acc_data_to_send});
      end
      if (sample_valid) begin
        sampleCyc.push_back(cyc);
        popCompare(1, "sample", {8'd0, accel_x, accel_y, accel_z});
      end
      if (man_ack) popCompare(2, "man_ack", {24'd0, man_rdata});
    end
  end

  function automatic logic [7:0] respFor(input logic [7:0] a);
    case (a)
      8'h08:   return rxX;
      8'h09:   return rxY;
      8'h0A:   return rxZ;
      8'h00:   return rxMan;
      default: return 8'hEE;
    endcase
  endfunction

  // Controller model: busy from the start pulse, one-cycle done after 'latency' cycles.
  initial begin
    int cnt;
    logic [7:0] a;
    accBusy = 1'b0;
    accDone = 1'b0;
    accRx   = 8'h00;
    cnt     = 0;
    a       = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      accDone = 1'b0;
      if (rst) begin
        accBusy = 1'b0;
      end else if (accBusy) begin
        if (cnt == 0) begin
          accBusy = 1'b0;
          accDone = 1'b1;
          accRx   = respFor(a);
        end else begin
          cnt--;
        end
      end else if (acc_start) begin
        accBusy = 1'b1;
        cnt     = latency - 1;
        a       = acc_address;
      end
    end
  end

  task automatic tickTb();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d);
    man_write = w;
    man_addr  = a;
    man_wdata = d;
    man_req   = 1'b1;
  endtask

  task automatic waitAck(input int maxCyc, input string name);
    int n = 0;
    while (!man_ack && n < maxCyc) begin
      tickTb();
      n++;
    end
    checkOutput(name, man_ack, 1'b1);
    man_req = 1'b0;
  endtask

  task automatic waitDrain(input int maxCyc, input string name);
    int n = 0;
    while (expQ.size() != 0 && n < maxCyc) begin
      tickTb();
      n++;
    end
    checkOutput(name, expQ.size(), 0);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int edges;
    int n;
    logic found, earlyAck;
    enable = 1'b0; man_req = 1'b0; man_write = 1'b0; man_addr = 8'h00; man_wdata = 8'h00;
    repeat (3) tickTb();
    checkOutput("reset_outputs", {init_done, overrun, sample_valid, man_ack, acc_start}, 5'd0);
    checkOutput("reset_accel", {8'd0, accel_x, accel_y, accel_z}, 32'd0);
    checkOutput("reset_bus", {acc_write, acc_address, acc_data_to_send, man_rdata}, 25'd0);

    // Power-up with a manual read already waiting during STARTUP.
    pushStart(1'b1, 8'h2D, 8'h02);
    pushStart(1'b0, 8'h00, 8'h00);
    pushAck(8'hAD);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 8'h00, 8'h00);
    edges = 0; found = 1'b0; earlyAck = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tickTb();
      edges++;
      if (man_ack) earlyAck = 1'b1;
      if (acc_start) found = 1'b1;
    end
    checkOutput("init_start_latency", edges, 21);
    checkOutput("ack_during_startup", earlyAck, 1'b0);
    n = 0;
    while (!accDone && n < 100) begin
      tickTb();
      n++;
    end
    checkOutput("init_done_at_done", init_done, 1'b0);
    tickTb();
    checkOutput("init_done_after_done", init_done, 1'b1);
    waitAck(200, "man_read_ack");
    tickTb();
    checkOutput("man_ack_single", man_ack, 1'b0);

    pushStart(1'b1, 8'h1F, 8'h52);
    pushAck(8'hAD);
    applyStimulus(1'b1, 8'h1F, 8'h52);
    waitAck(200, "man_write_ack");
    checkOutput("man_rdata_held", man_rdata, 8'hAD);
    repeat (300) tickTb();
    waitDrain(10, "drain_init");

    // Periodic sampling, 200-cycle period.
    rxX = 8'h11; rxY = 8'h22; rxZ = 8'h33;
    pushBurst(8'h11, 8'h22, 8'h33);
    pushBurst(8'h11, 8'h22, 8'h33);
    enable = 1'b1;
    waitDrain(1000, "drain_periodic");
    if (sampleCyc.size() >= 2) checkOutput("sample_period", sampleCyc[1] - sampleCyc[0], 200);
    else checkOutput("sample_count", sampleCyc.size(), 2);
    checkOutput("accel_periodic", {8'd0, accel_x, accel_y, accel_z}, 32'h00112233);

    // Manual request raised so it is seen on the same edge as the next tick.
    while (cyc < lastXStart + 198) tickTb();
    rxMan = 8'h5A;
    pushBurst(8'h11, 8'h22, 8'h33);
    pushStart(1'b0, 8'h00, 8'h00);
    pushAck(8'h5A);
    applyStimulus(1'b0, 8'h00, 8'h00);
    waitAck(400, "man_after_burst_ack");
    enable = 1'b0;
    waitDrain(400, "drain_priority");
    checkOutput("man_rdata_priority", man_rdata, 8'h5A);

    // Slow controller forces dropped ticks; enable drops mid-burst.
    latency = 150;
    rxX = 8'h44; rxY = 8'h55; rxZ = 8'h66;
    pushBurst(8'h44, 8'h55, 8'h66);
    checkOutput("overrun_clear", overrun, 1'b0);
    enable = 1'b1;
    n = 0;
    while (!overrun && n < 1500) begin
      tickTb();
      n++;
    end
    checkOutput("overrun_set", overrun, 1'b1);
    enable = 1'b0;
    waitDrain(1000, "drain_overrun");
    repeat (50) tickTb();
    checkOutput("overrun_sticky", overrun, 1'b1);
    checkOutput("accel_overrun", {8'd0, accel_x, accel_y, accel_z}, 32'h00445566);

    // Reset while waiting on the Y read.
    latency = 5;
    rxX = 8'h77; rxY = 8'h88; rxZ = 8'h99;
    pushStart(1'b0, 8'h08, 8'h00);
    pushStart(1'b0, 8'h09, 8'h00);
    enable = 1'b1;
    n = 0;
    while (!(acc_start && acc_address == 8'h09) && n < 400) begin
      tickTb();
      n++;
    end
    checkOutput("y_start_seen", acc_address, 8'h09);
    tickTb();
    tickTb();
    rst = 1'b1;
    #1;
    checkOutput("midreset_accel", {8'd0, accel_x, accel_y, accel_z}, 32'd0);
    checkOutput("midreset_flags", {init_done, overrun, sample_valid, man_ack, acc_start}, 5'd0);
    checkOutput("midreset_bus", {acc_write, acc_address, acc_data_to_send, man_rdata}, 25'd0);
    repeat (3) @(posedge clk);
    pushStart(1'b1, 8'h2D, 8'h02);
    pushBurst(8'h77, 8'h88, 8'h99);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (!init_done && n < 200) begin
      tickTb();
      n++;
    end
    checkOutput("reinit_done", init_done, 1'b1);
    checkOutput("accel_zero_after_reset", {8'd0, accel_x, accel_y, accel_z}, 32'd0);
    waitDrain(800, "drain_reset");
    enable = 1'b0;
    checkOutput("accel_after_reset_burst", {8'd0, accel_x, accel_y, accel_z}, 32'h00778899);
    repeat (20) tickTb();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
